// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared types, defaults and instruction field positions for instr_sequencer
package instr_sequencer_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_IW    = 14;

  localparam int OP_HI     = 13;
  localparam int OP_LO     = 12;
  localparam int WADDR_HI  = 11;
  localparam int WADDR_LO  = 8;
  localparam int RADDR1_HI = 7;
  localparam int RADDR1_LO = 4;
  localparam int RADDR2_HI = 3;
  localparam int RADDR2_LO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_sequencer_mem.sv
// rtl/instr_sequencer_mem.sv - DEPTH x IW program store, synchronous write, asynchronous read
module instr_mem #(
  parameter int DEPTH = 16,
  parameter int IW    = 14
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [IW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [IW-1:0]            o_rdata
);

  // Contents deliberately carry no reset so a program survives a sequencer reset.
  logic [IW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - loads a program into instr_mem and steps it out as FETCH/EXEC pairs
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IW    = DEFAULT_IW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [IW-1:0]            load_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     abort,
  output logic [IW-1:0]            instruction,
  output logic                     WE3,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_pc;
  logic [LW-1:0] r_len;
  logic [IW-1:0] r_instr;

  logic          w_idle;
  logic          w_load_fire;
  logic          w_start_ok;
  logic          w_last;
  logic [LW-1:0] w_len_clamped;
  logic [IW-1:0] w_mem_rdata;

  assign w_idle        = (r_state == S_IDLE);
  assign w_load_fire   = load_valid && w_idle;
  assign w_start_ok    = start && (prog_len != '0);
  assign w_len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
  assign w_last        = ({1'b0, r_pc} == (r_len - LW'(1)));

  instr_mem #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_load_fire),
    .i_waddr (load_addr),
    .i_wdata (load_data),
    .i_raddr (r_pc),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = abort ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // pc only advances out of a completed EXEC, so it can never pass len-1 <= DEPTH-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc    <= '0;
      r_len   <= '0;
      r_instr <= '0;
    end else begin
      if (w_idle && w_start_ok) begin
        r_len <= w_len_clamped;
        r_pc  <= '0;
      end
      if ((r_state == S_FETCH) && !abort) begin
        r_instr <= w_mem_rdata;
      end
      if ((r_state == S_EXEC) && !abort && !w_last) begin
        r_pc <= r_pc + AW'(1);
      end
    end
  end

  // abort gates WE3 combinationally so the datapath never commits an aborted write.
  assign WE3         = (r_state == S_EXEC) && !abort;
  assign busy        = (r_state == S_FETCH) || (r_state == S_EXEC);
  assign done        = (r_state == S_DONE);
  assign load_ready  = w_idle;
  assign instruction = r_instr;
  assign pc          = r_pc;

endmodule
